// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory: controller state
// encoding and the default fill word (ARM "B ." branch-to-self).
package imem_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_RUN   = 2'd1,
      ST_LOAD  = 2'd2
   } imem_state_e;

   localparam logic [31:0] IMEM_FILL_WORD = 32'hEAFF_FFFE;

endpackage

// File: rtl/imem_ram.sv
// Word-organised program storage: one synchronous write port and one
// asynchronous read port, so a same-word write is visible right after the edge.
module imem_ram #(
   parameter int ADDR_BITS = 4
) (
   input  logic                 clk,
   input  logic                 wr_en,
   input  logic [ADDR_BITS-1:0] wr_addr,
   input  logic [31:0]          wr_data,
   input  logic [ADDR_BITS-1:0] rd_addr,
   output logic [31:0]          rd_data
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   logic [31:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/imem_loadable.sv
// Runtime-loadable instruction memory: clears itself to the fill word after
// reset, accepts a word-serial program load, and stalls the core while busy.
module imem_loadable
   import imem_pkg::*;
#(
   parameter int          ADDR_BITS = 4,
   parameter int          REG_READ  = 0,
   parameter logic [31:0] FILL_WORD = IMEM_FILL_WORD
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          A,
   output logic [31:0]          RD,
   output logic                 hold,
   input  logic                 ld_start,
   input  logic                 ld_valid,
   input  logic [31:0]          ld_data,
   input  logic                 ld_last,
   output logic                 ld_ready,
   output logic                 ld_done,
   output logic [ADDR_BITS:0]   ld_count
);

   localparam logic [ADDR_BITS-1:0] PTR_ONE  = 1;
   localparam logic [ADDR_BITS-1:0] PTR_LAST = '1;
   localparam logic [ADDR_BITS:0]   CNT_ONE  = 1;

   imem_state_e state_q, state_d;

   logic [ADDR_BITS-1:0] ptr_q, ptr_d;
   logic [ADDR_BITS:0]   ld_count_q, ld_count_d;
   logic                 ld_done_q, ld_done_d;

   logic                 accept;
   logic                 load_end;
   logic                 clear_end;
   logic                 wr_en;
   logic [31:0]          wr_data;

   logic [ADDR_BITS-1:0] fetch_idx;
   logic                 fetch_oor;
   logic [31:0]          ram_rd;
   logic [31:0]          rd_d;
   logic [1:0]           unused_byte_offset;

   assign accept    = ld_ready && ld_valid;
   assign load_end  = accept && (ld_last || (ptr_q == PTR_LAST));
   assign clear_end = (state_q == ST_CLEAR) && (ptr_q == PTR_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_CLEAR;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_CLEAR: begin
            if (clear_end) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (ld_start) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (load_end) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   // Only RUN lets the core fetch; CLEAR and LOAD both own the write port.
   always_comb begin
      hold     = 1'b1;
      ld_ready = 1'b0;
      wr_en    = 1'b0;
      wr_data  = FILL_WORD;
      case (state_q)
         ST_CLEAR: begin
            wr_en = 1'b1;
         end
         ST_RUN: begin
            hold = 1'b0;
         end
         ST_LOAD: begin
            ld_ready = 1'b1;
            wr_en    = ld_valid;
            wr_data  = ld_data;
         end
         default: begin
            hold = 1'b1;
         end
      endcase
   end

   always_comb begin
      ptr_d      = ptr_q;
      ld_count_d = ld_count_q;
      ld_done_d  = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            ptr_d = ptr_q + PTR_ONE;
         end
         ST_RUN: begin
            if (ld_start) begin
               ptr_d      = '0;
               ld_count_d = '0;
            end
         end
         ST_LOAD: begin
            if (accept) begin
               ptr_d      = ptr_q + PTR_ONE;
               ld_count_d = ld_count_q + CNT_ONE;
            end
            ld_done_d = load_end;
         end
         default: begin
            ptr_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q      <= '0;
         ld_count_q <= '0;
         ld_done_q  <= 1'b0;
      end else begin
         ptr_q      <= ptr_d;
         ld_count_q <= ld_count_d;
         ld_done_q  <= ld_done_d;
      end
   end

   assign ld_done  = ld_done_q;
   assign ld_count = ld_count_q;

   imem_ram #(
      .ADDR_BITS (ADDR_BITS)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (ptr_q),
      .wr_data (wr_data),
      .rd_addr (fetch_idx),
      .rd_data (ram_rd)
   );

   // Byte offset is meaningless for word fetches; any high address bit means out of range.
   assign unused_byte_offset = A[1:0];
   assign fetch_idx          = A[ADDR_BITS+1:2];
   assign fetch_oor          = |A[31:ADDR_BITS+2];

   always_comb begin
      rd_d = ram_rd;
      if (hold || fetch_oor) begin
         rd_d = FILL_WORD;
      end
   end

   generate
      if (REG_READ != 0) begin : g_reg_read
         logic [31:0] rd_q;

         always_ff @(posedge clk) begin
            if (reset) begin
               rd_q <= FILL_WORD;
            end else begin
               rd_q <= rd_d;
            end
         end

         assign RD = rd_q;
      end else begin : g_comb_read
         assign RD = rd_d;
      end
   endgenerate

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable: drives a combinational-read and a
// registered-read instance from the same stimulus and checks both.
module tb_imem_loadable;

   localparam logic [31:0] FILL = 32'hEAFF_FFFE;

   logic        clk;
   logic        reset;
   logic [31:0] a;
   logic        ld_start;
   logic        ld_valid;
   logic [31:0] ld_data;
   logic        ld_last;

   logic [31:0] rd_c, rd_r;
   logic        hold_c, hold_r;
   logic        ld_ready_c, ld_ready_r;
   logic        ld_done_c, ld_done_r;
   logic [4:0]  ld_count_c, ld_count_r;

   int checks   = 0;
   int failures = 0;

   logic [31:0] prog [13] = '{
      32'hE032_2002, 32'hE282_3005, 32'hE282_400C, 32'hE244_7009,
      32'hE082_2004, 32'hE187_5002, 32'hE003_6005, 32'hE085_6004,
      32'hE056_8007, 32'h0A00_000C, 32'hE053_8004, 32'hE280_5000,
      32'hEAFF_FFFE
   };

   imem_loadable #(
      .ADDR_BITS (4),
      .REG_READ  (0),
      .FILL_WORD (FILL)
   ) dut_comb (
      .clk      (clk),
      .reset    (reset),
      .A        (a),
      .RD       (rd_c),
      .hold     (hold_c),
      .ld_start (ld_start),
      .ld_valid (ld_valid),
      .ld_data  (ld_data),
      .ld_last  (ld_last),
      .ld_ready (ld_ready_c),
      .ld_done  (ld_done_c),
      .ld_count (ld_count_c)
   );

   imem_loadable #(
      .ADDR_BITS (4),
      .REG_READ  (1),
      .FILL_WORD (FILL)
   ) dut_reg (
      .clk      (clk),
      .reset    (reset),
      .A        (a),
      .RD       (rd_r),
      .hold     (hold_r),
      .ld_start (ld_start),
      .ld_valid (ld_valid),
      .ld_data  (ld_data),
      .ld_last  (ld_last),
      .ld_ready (ld_ready_r),
      .ld_done  (ld_done_r),
      .ld_count (ld_count_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step_clock();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic start, input logic valid,
                                input logic [31:0] data, input logic last);
      ld_start = start;
      ld_valid = valid;
      ld_data  = data;
      ld_last  = last;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Combinational copy checked after settling, registered copy one edge later.
   task automatic check_fetch(input string tag, input logic [31:0] addr,
                              input logic [31:0] expected);
      a = addr;
      #1;
      checkOutput({tag, "_comb"}, rd_c, expected);
      step_clock();
      checkOutput({tag, "_reg"}, rd_r, expected);
   endtask

   initial begin
      reset = 1'b1;
      a     = 32'h0;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      step_clock();
      step_clock();
      reset = 1'b0;

      $display("[TB] reset state");
      checkOutput("rst_hold",     32'(hold_c),     32'd1);
      checkOutput("rst_ld_ready", 32'(ld_ready_c), 32'd0);
      checkOutput("rst_ld_done",  32'(ld_done_c),  32'd0);
      checkOutput("rst_ld_count", 32'(ld_count_c), 32'd0);
      checkOutput("rst_rd_comb",  rd_c,            FILL);
      checkOutput("rst_rd_reg",   rd_r,            FILL);

      $display("[TB] clear phase");
      for (int i = 1; i <= 16; i++) begin
         step_clock();
         checkOutput($sformatf("clr_hold_c%0d", i), 32'(hold_c), (i < 16) ? 32'd1 : 32'd0);
         checkOutput($sformatf("clr_hold_r%0d", i), 32'(hold_r), (i < 16) ? 32'd1 : 32'd0);
      end
      for (int i = 0; i < 16; i++) begin
         check_fetch($sformatf("clr_rd%0d", i), 32'(i * 4), FILL);
      end

      $display("[TB] demo program load");
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      step_clock();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("ld1_hold",     32'(hold_c),     32'd1);
      checkOutput("ld1_ready",    32'(ld_ready_c), 32'd1);
      checkOutput("ld1_count0",   32'(ld_count_c), 32'd0);
      for (int i = 0; i < 13; i++) begin
         applyStimulus(1'b0, 1'b1, prog[i], (i == 12));
         step_clock();
         if (i == 0) begin
            checkOutput("ld1_done_mid", 32'(ld_done_c), 32'd0);
         end
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("ld1_done",     32'(ld_done_c),  32'd1);
      checkOutput("ld1_count",    32'(ld_count_c), 32'd13);
      checkOutput("ld1_hold_end", 32'(hold_c),     32'd0);
      checkOutput("ld1_rdy_end",  32'(ld_ready_c), 32'd0);
      checkOutput("ld1_done_r",   32'(ld_done_r),  32'd1);
      step_clock();
      checkOutput("ld1_done_pulse", 32'(ld_done_c), 32'd0);

      check_fetch("rd_0x10",       32'h0000_0010, 32'hE082_2004);
      check_fetch("rd_0x30",       32'h0000_0030, 32'hEAFF_FFFE);
      check_fetch("rd_0x34",       32'h0000_0034, FILL);
      check_fetch("rd_0x11",       32'h0000_0011, 32'hE082_2004);
      check_fetch("rd_0x44",       32'h0000_0044, FILL);
      check_fetch("rd_0x80000000", 32'h8000_0000, FILL);
      check_fetch("rd_0x24",       32'h0000_0024, 32'h0A00_000C);

      $display("[TB] registered read latency");
      a = 32'h0;
      step_clock();
      checkOutput("lat_w0",      rd_r, 32'hE032_2002);
      a = 32'h4;
      #1;
      checkOutput("lat_w0_hold", rd_r, 32'hE032_2002);
      checkOutput("lat_comb_w1", rd_c, 32'hE282_3005);
      step_clock();
      checkOutput("lat_w1",      rd_r, 32'hE282_3005);

      $display("[TB] full load with overflow termination");
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      step_clock();
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 1'b1, 32'h1000_0000 + 32'(i), 1'b0);
         step_clock();
      end
      applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      checkOutput("ld2_count", 32'(ld_count_c), 32'd16);
      checkOutput("ld2_ready", 32'(ld_ready_c), 32'd0);
      checkOutput("ld2_done",  32'(ld_done_c),  32'd1);
      checkOutput("ld2_hold",  32'(hold_c),     32'd0);
      step_clock();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("ld2_count_after", 32'(ld_count_c), 32'd16);
      checkOutput("ld2_done_after",  32'(ld_done_c),  32'd0);
      check_fetch("ld2_w0",  32'h0000_0000, 32'h1000_0000);
      check_fetch("ld2_w7",  32'h0000_001C, 32'h1000_0007);
      check_fetch("ld2_w15", 32'h0000_003C, 32'h1000_000F);

      $display("[TB] reset during load");
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      step_clock();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b1, 32'h2000_0000 + 32'(i), 1'b0);
         step_clock();
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      reset = 1'b1;
      step_clock();
      reset = 1'b0;
      checkOutput("rl_hold",  32'(hold_c),     32'd1);
      checkOutput("rl_count", 32'(ld_count_c), 32'd0);
      checkOutput("rl_done",  32'(ld_done_c),  32'd0);
      checkOutput("rl_ready", 32'(ld_ready_c), 32'd0);
      for (int i = 1; i <= 16; i++) begin
         step_clock();
         checkOutput($sformatf("rl_hold%0d", i), 32'(hold_c), (i < 16) ? 32'd1 : 32'd0);
         checkOutput($sformatf("rl_done%0d", i), 32'(ld_done_c), 32'd0);
      end
      checkOutput("rl_count_run", 32'(ld_count_c), 32'd0);
      for (int i = 0; i < 16; i++) begin
         check_fetch($sformatf("rl_rd%0d", i), 32'(i * 4), FILL);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imem_loadable.md
# imem_loadable

Parametrised, runtime-loadable instruction memory for the ARM single-cycle and pipelined cores. It replaces the hard-wired program ROM with a word-addressed RAM. After reset it is filled with a branch-to-self word. A word-serial loader port then writes a program into it. `hold` stalls the core while contents are not valid. Fetch read is either combinational (single-cycle core) or registered (pipelined core), chosen by parameter.

## Interface
Parameters:
- `ADDR_BITS`, 4: word-address width; `DEPTH` = 2**`ADDR_BITS` words.
- `REG_READ`, 0: 0 = combinational fetch read; 1 = registered fetch read, 1-cycle latency.
- `FILL_WORD`, 32'hEAFF_FFFE: clear value and out-of-range/held read value (`BAL .`).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `A`  in  32  fetch byte address; `A[1:0]` ignored.
- `RD`  out  32  fetched instruction.
- `hold`  out  1  high while clearing or loading; core must not fetch.
- `ld_start`  in  1  single-cycle request to begin a load (honoured only in RUN).
- `ld_valid`  in  1  `ld_data` valid.
- `ld_data`  in  32  program word.
- `ld_last`  in  1  qualifies the final word of a load.
- `ld_ready`  out  1  loader may present words (high only in LOAD).
- `ld_done`  out  1  one-cycle pulse when a load completes.
- `ld_count`  out  `ADDR_BITS`+1  words written by the most recent load.

## Operation
- States: CLEAR, RUN, LOAD.
- CLEAR:
  - Write `FILL_WORD` at `ptr`, one word per cycle.
  - `ptr` increments; after writing `DEPTH-1`, go to RUN.
  - `ld_start` ignored.
- RUN:
  - `hold`=0.
  - `ld_start`=1 → LOAD, with `ptr`←0 and `ld_count`←0.
  - `ld_valid` without a load in progress is ignored.
- LOAD:
  - `ld_ready`=1. A word is written at `ptr` on `ld_valid && ld_ready`; `ptr` and `ld_count` increment.
  - Termination: accepted word with `ld_last`=1, or accepted word at `ptr`=`DEPTH-1` (overflow guard). Either → RUN and `ld_done`=1 for the next cycle.
  - Unwritten words keep their prior contents.
  - `ld_start` while in LOAD is ignored.
- Fetch decode:
  - Index = `A[ADDR_BITS+1:2]`.
  - If any `A[31:ADDR_BITS+2]` bit is 1, `RD`=`FILL_WORD`.
  - While `hold`=1, `RD`=`FILL_WORD`.
- Write and read same word in the same cycle: the read returns old data (REG_READ=1) or new data after the edge (REG_READ=0, combinational).

## Timing
- Reset values:
  - state=CLEAR, `ptr`=0, `hold`=1.
  - `ld_ready`=0, `ld_done`=0, `ld_count`=0.
  - `RD`=`FILL_WORD` (including the registered copy).
- CLEAR lasts exactly `DEPTH` cycles after reset deasserts. `hold` falls on cycle `DEPTH`+1.
- LOAD entry: cycle after `ld_start`; `hold` and `ld_ready` rise together.
- `ld_done` and `hold`=0 occur in the cycle after the terminating write.
- REG_READ=0: `RD` is valid in the same cycle as `A`.
- REG_READ=1: `RD` reflects the `A` sampled at the previous edge.
- Reset mid-CLEAR or mid-LOAD: restart CLEAR from 0. Partial program lost; `ld_count`=0; no `ld_done`.

## Structure
- Package `imem_pkg`: state encoding (CLEAR/RUN/LOAD) and default `FILL_WORD` constant.
- Sub-module `imem_ram`: `DEPTH`×32 array, one synchronous write port, one asynchronous read port.
- Top: FSM, `ptr`, range check, hold mux, optional read register.

## Test plan
- Reset 1 cycle, `ADDR_BITS`=4 → `hold`=1 for 16 cycles, low at cycle 17. Every `A` 0x00–0x3C then reads 0xEAFFFFFE.
- Load the 13-word demo program (0xE0322002 … 0xEAFFFFFE) with `ld_last` on word 13:
  - `ld_done` pulses once, `ld_count`=13.
  - `A`=0x10 → 0xE0822004; `A`=0x30 → 0xEAFFFFFE; `A`=0x34 → 0xEAFFFFFE.
- Load 16 words with no `ld_last` → auto-terminate after word 16: `ld_count`=16, `ld_ready` drops. A 17th `ld_valid` word is not written.
- `A`=0x11 reads the same as 0x10. `A`=0x44 and `A`=0x8000_0000 → 0xEAFFFFFE.
- `REG_READ`=1: step `A` 0x00→0x04 → `RD` changes one edge later. Pattern 0x00 then 0x04 yields word0 then word1.
- Assert `reset` after 5 words of a load:
  - `hold`=1 for 16 cycles, `ld_count`=0, no `ld_done`.
  - All 16 words then read 0xEAFFFFFE.
